// File: rtl/rc4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rc4_pkg
// Brief    : Shared types, constants and helpers for the RC4 key-search array.
// Revision : 1.0 - initial release
// ============================================================================
package rc4_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_CAPT = 3'd2,
      ST_EMIT = 3'd3,
      ST_DONE = 3'd4
   } readout_state_t;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_LO    = 8'h61;
   localparam logic [7:0] ASCII_HI    = 8'h7A;

   // A plaintext byte is acceptable when it is a lowercase letter or a space.
   function automatic logic is_msg_char(input logic [7:0] b);
      return (b == ASCII_SPACE) || ((b >= ASCII_LO) && (b <= ASCII_HI));
   endfunction

endpackage
`default_nettype wire

// File: rtl/readout_fsm.sv
`default_nettype none
// ============================================================================
// Module   : readout_fsm
// Brief    : Readout sequencer: state register, byte index and message check.
// Revision : 1.0 - initial release
// ============================================================================
module readout_fsm
   import rc4_pkg::*;
#(
   parameter int MESSAGE_LENGTH     = 32,
   parameter int MESSAGE_LOG_LENGTH = 5,
   parameter int RAM_WIDTH          = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          found,
   input  logic                          out_ready,
   input  logic [RAM_WIDTH-1:0]          rd_data,
   output readout_state_t                state,
   output logic [MESSAGE_LOG_LENGTH-1:0] idx,
   output logic                          last_byte,
   output logic                          ok
);

   localparam logic [MESSAGE_LOG_LENGTH-1:0] c_last_idx =
      MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);
   localparam logic [MESSAGE_LOG_LENGTH-1:0] c_idx_one =
      MESSAGE_LOG_LENGTH'(1);

   readout_state_t                r_state;
   readout_state_t                w_state_nxt;
   logic [MESSAGE_LOG_LENGTH-1:0] r_idx;
   logic [MESSAGE_LOG_LENGTH-1:0] w_idx_nxt;
   logic                          r_ok;
   logic                          w_ok_nxt;
   logic                          w_last;
   logic [7:0]                    w_byte;

   assign w_byte = 8'(rd_data);
   // Last-byte test is made on the current index, so the counter never wraps.
   assign w_last = (r_idx == c_last_idx);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_ok    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_ok    <= w_ok_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_ok_nxt    = r_ok;
      if (clear) begin
         w_state_nxt = ST_IDLE;
         w_idx_nxt   = '0;
         w_ok_nxt    = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (found) begin
                  w_state_nxt = ST_ADDR;
                  w_idx_nxt   = '0;
                  w_ok_nxt    = 1'b1;
               end
            end
            ST_ADDR: begin
               w_state_nxt = ST_CAPT;
            end
            ST_CAPT: begin
               w_ok_nxt    = r_ok & is_msg_char(w_byte);
               w_state_nxt = ST_EMIT;
            end
            ST_EMIT: begin
               if (out_ready) begin
                  if (w_last) begin
                     w_state_nxt = ST_DONE;
                  end else begin
                     w_idx_nxt   = r_idx + c_idx_one;
                     w_state_nxt = ST_ADDR;
                  end
               end
            end
            ST_DONE: begin
               w_state_nxt = ST_DONE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_idx_nxt   = '0;
               w_ok_nxt    = 1'b1;
            end
         endcase
      end
   end

   assign state     = r_state;
   assign idx       = r_idx;
   assign last_byte = w_last;
   assign ok        = r_ok;

endmodule
`default_nettype wire

// File: rtl/message_readout.sv
`default_nettype none
// ============================================================================
// Module   : message_readout
// Brief    : Latches the winning core/key and streams its decrypted message.
// Revision : 1.0 - initial release
// ============================================================================
module message_readout
   import rc4_pkg::*;
#(
   parameter int LOG_NUM_CORES      = 8,
   parameter int MESSAGE_LENGTH     = 32,
   parameter int MESSAGE_LOG_LENGTH = 5,
   parameter int KEY_LENGTH         = 3,
   parameter int RAM_WIDTH          = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          found,
   input  logic [LOG_NUM_CORES-1:0]      core_ptr,
   input  logic [KEY_LENGTH*8-1:0]       found_key,
   output logic [LOG_NUM_CORES-1:0]      rd_sel,
   output logic [MESSAGE_LOG_LENGTH-1:0] rd_addr,
   input  logic [RAM_WIDTH-1:0]          rd_data,
   output logic [RAM_WIDTH-1:0]          out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last,
   output logic [KEY_LENGTH*8-1:0]       key_out,
   output logic                          key_valid,
   output logic                          busy,
   output logic                          done,
   output logic                          msg_ok
);

   readout_state_t                w_state;
   logic [MESSAGE_LOG_LENGTH-1:0] w_idx;
   logic                          w_last_byte;
   logic                          w_ok;
   logic                          w_start;
   logic                          w_capture;

   logic [LOG_NUM_CORES-1:0]      r_rd_sel;
   logic [KEY_LENGTH*8-1:0]       r_key;
   logic                          r_key_valid;
   logic [RAM_WIDTH-1:0]          r_out_data;

   readout_fsm #(
      .MESSAGE_LENGTH     (MESSAGE_LENGTH),
      .MESSAGE_LOG_LENGTH (MESSAGE_LOG_LENGTH),
      .RAM_WIDTH          (RAM_WIDTH)
   ) u_fsm (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .found     (found),
      .out_ready (out_ready),
      .rd_data   (rd_data),
      .state     (w_state),
      .idx       (w_idx),
      .last_byte (w_last_byte),
      .ok        (w_ok)
   );

   // Latches only open in IDLE, so late changes on the array side are ignored.
   assign w_start   = (w_state == ST_IDLE) && found && !clear;
   assign w_capture = (w_state == ST_CAPT) && !clear;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rd_sel    <= '0;
         r_key       <= '0;
         r_key_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (clear) begin
         r_rd_sel    <= '0;
         r_key       <= '0;
         r_key_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         if (w_start) begin
            r_rd_sel    <= core_ptr;
            r_key       <= found_key;
            r_key_valid <= 1'b1;
         end
         if (w_capture) begin
            r_out_data <= rd_data;
         end
      end
   end

   assign rd_sel    = r_rd_sel;
   assign rd_addr   = w_idx;
   assign out_data  = r_out_data;
   assign out_valid = (w_state == ST_EMIT);
   assign out_last  = (w_state == ST_EMIT) && w_last_byte;
   assign key_out   = r_key;
   assign key_valid = r_key_valid;
   assign busy      = (w_state == ST_ADDR) || (w_state == ST_CAPT) ||
                      (w_state == ST_EMIT);
   assign done      = (w_state == ST_DONE);
   assign msg_ok    = (w_state == ST_DONE) && w_ok;

endmodule
`default_nettype wire

// File: tb/tb_message_readout.sv
`default_nettype none
// ============================================================================
// Module   : tb_message_readout
// Brief    : Self-checking bench for message_readout against a stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_message_readout;

   localparam int ML = 32;

   logic        clk = 1'b0;
   logic        reset, clear, found, out_ready;
   logic [7:0]  core_ptr;
   logic [23:0] found_key;
   logic [7:0]  rd_sel;
   logic [4:0]  rd_addr;
   logic [7:0]  rd_data;
   logic [7:0]  out_data;
   logic        out_valid, out_last, key_valid, busy, done, msg_ok;
   logic [23:0] key_out;

   logic [7:0]  ram [0:ML-1];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int         pos;
      logic [7:0] val;
      bit         exp_ok;
   } vec_t;

   vec_t vt [10];

   message_readout dut (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .found     (found),
      .core_ptr  (core_ptr),
      .found_key (found_key),
      .rd_sel    (rd_sel),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .key_out   (key_out),
      .key_valid (key_valid),
      .busy      (busy),
      .done      (done),
      .msg_ok    (msg_ok)
   );

   always #5 clk = ~clk;

   // Message RAM with one-cycle read latency
   always @(posedge clk) rd_data <= ram[rd_addr];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {13'd0, rd_sel, rd_addr, out_data, out_valid, out_last, key_out,
              key_valid, busy, done, msg_ok};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic bit model_ok();
      bit r = 1'b1;
      for (int i = 0; i < ML; i++)
         if (!(ram[i] == 8'h20 || (ram[i] >= 8'h61 && ram[i] <= 8'h7a))) r = 1'b0;
      return r;
   endfunction

   task automatic load_nominal();
      string s = "abc defghijklmnopqrstuvwxyz abcd";
      for (int i = 0; i < ML; i++) ram[i] = s[i];
   endtask

   task automatic do_clear();
      found = 1'b0;
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("after_clear", outs(), 64'd0);
   endtask

   // mode 0: ready high, 1: random ready, 2: 4-cycle stall on byte 7
   task automatic run_readout(input int mode, input logic [7:0] ptr,
                              input logic [23:0] key, input bit perturb);
      int         cycles = 0, first_valid = -1, stalls = 0, stall_run = 0, done_cyc = -1;
      int         errs = 0;
      bit         hold = 1'b0;
      logic [7:0] hdata = 8'd0;
      logic       hlast = 1'b0;
      logic [7:0] got [$];
      core_ptr  = ptr;
      found_key = key;
      found     = 1'b1;
      out_ready = 1'b1;
      while (cycles < 1000) begin
         step();
         cycles++;
         check("latched", {rd_sel, key_out, key_valid}, {ptr, key, 1'b1});
         if (done) begin
            done_cyc = cycles;
            break;
         end
         check("busy", busy, 1'b1);
         if (perturb) begin
            core_ptr  = 8'($urandom);
            found_key = 24'($urandom);
         end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = !(out_valid && got.size() == 6 && stall_run < 4);
         endcase
         if (mode == 2 && !out_ready) stall_run++;
         if (hold) begin
            check("valid_held", out_valid, 1'b1);
            check("data_held", {out_data, out_last}, {hdata, hlast});
         end
         if (out_valid) begin
            if (first_valid < 0) first_valid = cycles;
            if (out_ready) begin
               check("last_flag", out_last, got.size() == ML - 1);
               got.push_back(out_data);
               hold = 1'b0;
            end else begin
               stalls++;
               hold  = 1'b1;
               hdata = out_data;
               hlast = out_last;
            end
         end
      end
      check("no_timeout", done_cyc > 0, 1'b1);
      check("first_valid_latency", first_valid, 3);
      check("done_cycle", done_cyc, 3 * ML + 1 + stalls);
      check("byte_count", got.size(), ML);
      for (int i = 0; i < ML; i++)
         if (i >= got.size() || got[i] !== ram[i]) errs++;
      check("stream", errs, 0);
      check("msg_ok", msg_ok, model_ok());
      check("done_flags", {busy, out_valid}, 2'b00);
   endtask

   initial begin
      int n, cyc;
      vt[0] = '{10, 8'h41, 1'b0};
      vt[1] = '{0,  8'h20, 1'b1};
      vt[2] = '{31, 8'h7a, 1'b1};
      vt[3] = '{5,  8'h61, 1'b1};
      vt[4] = '{10, 8'h60, 1'b0};
      vt[5] = '{10, 8'h7b, 1'b0};
      vt[6] = '{31, 8'h1f, 1'b0};
      vt[7] = '{0,  8'h21, 1'b0};
      vt[8] = '{3,  8'h00, 1'b0};
      vt[9] = '{20, 8'hff, 1'b0};

      reset = 1'b0; clear = 1'b0; found = 1'b0; out_ready = 1'b0;
      core_ptr = 8'd0; found_key = 24'd0;
      load_nominal();
      repeat (3) step();
      check("reset_outputs", outs(), 64'd0);
      reset = 1'b1;
      step();
      check("idle_no_found", outs(), 64'd0);

      // Nominal readout, then found held high in DONE must not re-trigger
      run_readout(0, 8'h05, 24'h00014A, 1'b0);
      check("nominal_msg_ok", msg_ok, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("done_hold", {done, busy, msg_ok, out_valid}, 4'b1010);
      end
      do_clear();

      run_readout(2, 8'h05, 24'h00014A, 1'b0);
      do_clear();
      run_readout(0, 8'h05, 24'h00014A, 1'b1);
      do_clear();

      foreach (vt[k]) begin
         load_nominal();
         ram[vt[k].pos] = vt[k].val;
         run_readout(0, 8'(k), 24'h123456, 1'b0);
         check("table_msg_ok", msg_ok, vt[k].exp_ok);
         do_clear();
      end

      // clear and found together: clear wins, readout starts one cycle later
      load_nominal();
      core_ptr = 8'h33; found = 1'b1; clear = 1'b1;
      step();
      clear = 1'b0;
      check("clear_beats_found", outs(), 64'd0);
      step();
      check("start_after_clear", {busy, rd_sel}, {1'b1, 8'h33});
      do_clear();

      // clear while byte 12 is stalled (with ready raised in the same cycle)
      core_ptr = 8'h05; found_key = 24'h00014A; found = 1'b1; out_ready = 1'b1;
      n = 0; cyc = 0;
      while (cyc < 500) begin
         step();
         cyc++;
         if (out_valid) begin
            if (n == 11) break;
            n++;
         end
      end
      check("reached_byte12", n, 11);
      out_ready = 1'b0;
      step();
      step();
      check("byte12_held", {out_valid, out_data}, {1'b1, ram[11]});
      clear = 1'b1; out_ready = 1'b1; found = 1'b0;
      step();
      clear = 1'b0;
      check("clear_mid", outs(), 64'd0);
      run_readout(0, 8'h05, 24'h00014A, 1'b0);
      do_clear();

      // asynchronous reset while in EMIT
      core_ptr = 8'h05; found = 1'b1; out_ready = 1'b0;
      cyc = 0;
      while (cyc < 20 && !out_valid) begin
         step();
         cyc++;
      end
      check("reach_emit", out_valid, 1'b1);
      #3;
      reset = 1'b0;
      #1;
      check("async_reset", outs(), 64'd0);
      step();
      step();
      reset = 1'b1;
      step();
      check("release_c1", {busy, out_valid}, 2'b10);
      step();
      check("release_c2", {busy, out_valid}, 2'b10);
      step();
      check("release_c3", {busy, out_valid}, 2'b11);
      do_clear();

      // randomized messages, ready pattern and late input changes
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < ML; i++) begin
            int v = $urandom_range(0, 26);
            if (r % 2 == 1 && $urandom_range(0, 9) == 0) ram[i] = 8'($urandom);
            else ram[i] = (v == 26) ? 8'h20 : 8'(8'h61 + v);
         end
         run_readout(1, 8'($urandom), 24'($urandom), 1'b1);
         do_clear();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/message_readout.md
# message_readout

Downstream stage of the parallel RC4 key-search array. When the success flag rises, it latches the winning core index and that core's key. It then walks the winner's decrypted-message RAM through a one-cycle-latency read port. Each byte is presented on a valid/ready stream, and the block checks that the whole message is lowercase ASCII or space.

## Interface
Parameters:
- LOG_NUM_CORES, 8, width of core index
- MESSAGE_LENGTH, 32, bytes per message
- MESSAGE_LOG_LENGTH, 5, width of message address
- KEY_LENGTH, 3, key bytes
- RAM_WIDTH, 8, byte width

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low
- clear  in  1  sync one-cycle pulse (start edge); abort and return to IDLE
- found  in  1  success level from array (sticky until clear)
- core_ptr  in  LOG_NUM_CORES  index of winning core
- found_key  in  KEY_LENGTH*8  key of winning core
- rd_sel  out  LOG_NUM_CORES  core select for the A-RAM read mux
- rd_addr  out  MESSAGE_LOG_LENGTH  A-RAM read address
- rd_data  in  RAM_WIDTH  A-RAM q, valid one cycle after rd_addr
- out_data  out  RAM_WIDTH  message byte
- out_valid  out  1  byte valid
- out_ready  in  1  sink accepts
- out_last  out  1  final byte marker, qualified by out_valid
- key_out  out  KEY_LENGTH*8  latched key, for the HEX display
- key_valid  out  1  key_out meaningful
- busy  out  1  readout in progress
- done  out  1  all bytes accepted
- msg_ok  out  1  every byte in 0x61..0x7A or 0x20; valid when done=1

## Operation
- States: IDLE, ADDR, CAPT, EMIT, DONE.
- IDLE:
  - On found=1: latch core_ptr into rd_sel and found_key into key_out.
  - Set key_valid=1, idx=0, ok=1; go to ADDR.
- ADDR: drive rd_addr=idx; go to CAPT.
- CAPT:
  - Register rd_data into out_data.
  - ok &= (rd_data==0x20 or 0x61<=rd_data<=0x7A).
  - Go to EMIT.
- EMIT:
  - out_valid=1, out_last=(idx==MESSAGE_LENGTH-1).
  - On out_ready: if last, go to DONE; else idx+1, go to ADDR.
- DONE: done=1, msg_ok=ok. Hold until clear or reset.
- rd_addr holds idx in every state (stable through CAPT).
- idx is MESSAGE_LOG_LENGTH wide. It never wraps; the last-byte compare precedes the increment.
- While not in IDLE, found and changes on core_ptr or found_key are ignored; latched values stay frozen.
- clear in any state:
  - Go to IDLE on the next edge.
  - out_valid, busy, done, key_valid drop to 0.
  - key_out, rd_sel, out_data, idx zeroed.
  - Takes priority over every same-cycle transition, including out_ready acceptance.
- clear and found in the same cycle: clear wins and stays in IDLE. Readout starts the next cycle if found is still 1.
- found stays high in DONE: no re-trigger until clear.

## Timing
- Reset values (asynchronous on reset=0): state IDLE; all outputs 0; ok=1.
- Latency, found rising to first out_valid: 3 cycles (IDLE→ADDR→CAPT→EMIT).
- Per byte: 3 cycles with out_ready tied high. Full message: 3*MESSAGE_LENGTH+1 cycles from found to done.
- Handshake:
  - Transfer on out_valid && out_ready at the clock edge.
  - out_data and out_last stable while out_valid=1 and out_ready=0.
  - out_valid never drops without a transfer, except on clear or reset.
- busy=1 exactly in ADDR, CAPT and EMIT.
- done asserts the cycle after the last transfer.
- Reset deasserted mid-readout restarts from IDLE. Readout begins again if found is still high.

## Structure
- Shared package rc4_pkg:
  - readout_state_t enum.
  - Constants ASCII_SPACE=8'h20, ASCII_LO=8'h61, ASCII_HI=8'h7A.
  - Function is_msg_char(byte); also usable by the arcfour cores.
- One sub-module, readout_fsm (state register, idx counter, ok accumulator). The top file holds the latches and the output registers.
- The per-core A RAMs gain a read-data port. The RAM-select mux indexed by rd_sel lives in the array top, not in this block.

## Test plan
- Nominal: core_ptr=8'h05, found_key=24'h00_01_4A, RAM = "abc defghijklmnopqrstuvwxyz abcd", out_ready=1 -> rd_sel=5, key_out=24'h00014A, 32 bytes in order, out_last on byte 32, done at cycle 97, msg_ok=1.
- Backpressure: out_ready=0 for 4 cycles at byte 7 -> out_data (byte 7) and out_valid held; no byte skipped or duplicated; final count 32.
- Bad byte: RAM[10]=8'h41 -> stream completes, done=1, msg_ok=0.
- Clear mid-readout: clear pulse at byte 12 while out_ready=0 -> next cycle IDLE, all outputs 0. Re-run with found=1 restarts at address 0.
- Async reset in EMIT: reset=0 between edges -> outputs 0 immediately. With found held, first out_valid comes 3 cycles after reset release.
- Late inputs ignored: core_ptr changes 5→9 during readout -> rd_sel stays 5 until done.
